// File: rtl/wbs_pwm_adv_if.sv
// Wishbone-style slave bus bundle shared by the PWM block and its bench.
interface wishbone;
    logic        clk;
    logic        rst;
    logic        stb;
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat_c;
    logic [31:0] dat_p;
    logic        ack;

    modport slave (input clk, rst, stb, we, adr, dat_c, output dat_p, ack);
endinterface

// File: rtl/wbs_pwm_adv.sv
// Multi-channel PWM generator with prescaler, edge/center counting, shadowed duty
// registers that load at the period boundary, and per-channel output polarity.
module wbs_pwm_adv #(
    parameter int CHANNEL_NUM   = 4,
    parameter int RES_BITS      = 8,
    parameter int PRESCALE_BITS = 16
) (
    wishbone.slave                wb,
    output logic [CHANNEL_NUM-1:0] pwm_channel
);

    localparam logic [RES_BITS-1:0]      CNT_MAX  = {RES_BITS{1'b1}};
    localparam logic [RES_BITS-1:0]      CNT_ZERO = {RES_BITS{1'b0}};
    localparam logic [RES_BITS-1:0]      CNT_ONE  = RES_BITS'(1);
    localparam logic [PRESCALE_BITS-1:0] PRE_ZERO = {PRESCALE_BITS{1'b0}};
    localparam logic [PRESCALE_BITS-1:0] PRE_ONE  = PRESCALE_BITS'(1);
    localparam logic [7:0] ADR_CTRL = 8'h00;
    localparam logic [7:0] ADR_PRE  = 8'h01;
    localparam logic [7:0] ADR_POL  = 8'h02;
    localparam logic [7:0] ADR_CNT  = 8'h03;
    localparam logic [7:0] ADR_DUTY = 8'h10;

    logic                     ack_r;
    logic [31:0]              dat_r;
    logic                     en_r;
    logic                     center_r;
    logic [PRESCALE_BITS-1:0] prescale_r;
    logic [PRESCALE_BITS-1:0] pre_cnt_r;
    logic [CHANNEL_NUM-1:0]   polarity_r;
    logic [CHANNEL_NUM-1:0]   pwm_r;
    logic [RES_BITS:0]        shadow_r     [CHANNEL_NUM];
    logic [RES_BITS:0]        active_r     [CHANNEL_NUM];
    logic [RES_BITS:0]        shadow_nxt_s [CHANNEL_NUM];
    logic [RES_BITS-1:0]      cnt_r;
    logic [RES_BITS-1:0]      cnt_nxt_s;
    logic                     dir_down_r;
    logic                     dir_nxt_s;
    logic                     acc_s;
    logic                     wr_s;
    logic                     ctrl_wr_s;
    logic                     pre_wr_s;
    logic                     restart_s;
    logic                     tick_s;
    logic                     load_s;
    logic [31:0]              rdata_s;
    logic                     unused_s;

    assign acc_s     = wb.stb & ~ack_r;
    assign wr_s      = acc_s & wb.we;
    assign ctrl_wr_s = wr_s & (wb.adr == ADR_CTRL);
    assign pre_wr_s  = wr_s & (wb.adr == ADR_PRE);
    assign restart_s = ctrl_wr_s & en_r & (wb.dat_c[1] != center_r);
    assign tick_s    = en_r & (pre_cnt_r >= prescale_r);
    // Period boundary: the tick on which the counter returns to zero.
    assign load_s    = tick_s & (cnt_nxt_s == CNT_ZERO);
    assign unused_s  = &{1'b0, wb.dat_c};

    assign wb.ack      = ack_r;
    assign wb.dat_p    = dat_r;
    assign pwm_channel = pwm_r;

    // Read data multiplexer; unmapped addresses and unused bits return zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (wb.adr)
            ADR_CTRL: rdata_s[1:0]               = {center_r, en_r};
            ADR_PRE:  rdata_s[PRESCALE_BITS-1:0] = prescale_r;
            ADR_POL:  rdata_s[CHANNEL_NUM-1:0]   = polarity_r;
            ADR_CNT:  rdata_s[RES_BITS-1:0]      = cnt_r;
            default: begin
                for (int i = 0; i < CHANNEL_NUM; i++) begin
                    if (wb.adr == ADR_DUTY + 8'(i)) begin
                        rdata_s[RES_BITS:0] = shadow_r[i];
                    end else begin
                        rdata_s = rdata_s;
                    end
                end
            end
        endcase
    end

    // Shadow values including a write landing this cycle, so a coincident load sees it.
    always_comb begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (wr_s && (wb.adr == ADR_DUTY + 8'(i))) begin
                shadow_nxt_s[i] = wb.dat_c[RES_BITS:0];
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
        end
    end

    // Next counter value and direction for edge and center modes.
    always_comb begin
        cnt_nxt_s = cnt_r;
        dir_nxt_s = dir_down_r;
        if (!center_r) begin
            cnt_nxt_s = (cnt_r == CNT_MAX) ? CNT_ZERO : cnt_r + CNT_ONE;
            dir_nxt_s = 1'b0;
        end else if (!dir_down_r) begin
            if (cnt_r == CNT_MAX) begin
                cnt_nxt_s = CNT_MAX - CNT_ONE;
                dir_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
                dir_nxt_s = 1'b0;
            end
        end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
            dir_nxt_s = (cnt_r != CNT_ONE);
        end
    end

    // Bus handshake: single-cycle ack with registered read data.
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= wb.stb & ~ack_r;
            dat_r <= acc_s ? rdata_s : 32'h0000_0000;
        end
    end

    // Configuration and shadow duty registers.
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            en_r       <= 1'b0;
            center_r   <= 1'b0;
            prescale_r <= PRE_ZERO;
            polarity_r <= {CHANNEL_NUM{1'b0}};
            for (int i = 0; i < CHANNEL_NUM; i++) shadow_r[i] <= {(RES_BITS+1){1'b0}};
        end else begin
            if (ctrl_wr_s) begin
                en_r     <= wb.dat_c[0];
                center_r <= wb.dat_c[1];
            end
            if (pre_wr_s) prescale_r <= wb.dat_c[PRESCALE_BITS-1:0];
            if (wr_s && (wb.adr == ADR_POL)) polarity_r <= wb.dat_c[CHANNEL_NUM-1:0];
            for (int i = 0; i < CHANNEL_NUM; i++) shadow_r[i] <= shadow_nxt_s[i];
        end
    end

    // Prescaler, period counter and active duty registers.
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            pre_cnt_r  <= PRE_ZERO;
            cnt_r      <= CNT_ZERO;
            dir_down_r <= 1'b0;
            for (int i = 0; i < CHANNEL_NUM; i++) active_r[i] <= {(RES_BITS+1){1'b0}};
        end else if (!en_r || restart_s) begin
            pre_cnt_r  <= PRE_ZERO;
            cnt_r      <= CNT_ZERO;
            dir_down_r <= 1'b0;
            for (int i = 0; i < CHANNEL_NUM; i++) active_r[i] <= shadow_nxt_s[i];
        end else begin
            pre_cnt_r <= (pre_wr_s || tick_s) ? PRE_ZERO : pre_cnt_r + PRE_ONE;
            if (tick_s) begin
                cnt_r      <= cnt_nxt_s;
                dir_down_r <= dir_nxt_s;
            end
            if (load_s) begin
                for (int i = 0; i < CHANNEL_NUM; i++) active_r[i] <= shadow_nxt_s[i];
            end
        end
    end

    // Registered channel outputs with polarity applied.
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            pwm_r <= {CHANNEL_NUM{1'b0}};
        end else if (!en_r) begin
            pwm_r <= polarity_r;
        end else begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                pwm_r[i] <= ({1'b0, cnt_r} < active_r[i]) ^ polarity_r[i];
            end
        end
    end

endmodule
